// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types and defaults for the pipeline hazard controller
//
// Purpose : divider FSM state encoding, per-stage stall/flush control
//           bundles and the EXE register-file write-type struct.
// Ports   : none (package).
package hazard_ctrl_pkg;

    localparam int DIV_CYCLES_DEF = 32;
    localparam int CNT_W_DEF      = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } DivState_t;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_exe;
        logic exe_mem;
        logic mem_wb;
    } StallCtrl_t;

    typedef struct packed {
        logic if_id;
        logic id_exe;
        logic exe_mem;
    } FlushCtrl_t;

    // Destination write enables carried down the pipe with each instruction.
    typedef struct packed {
        logic RFWr;
        logic HIWr;
        logic LOWr;
    } RegsWrType;

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline status in / stall-flush controls out bundle
//
// Purpose : groups the hazard controller's pipeline-facing signals.
// Ports   : master = pipeline side (drives ID/EXE/MEM status, receives
//           stall/flush/divider status); slave = hazard_ctrl.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic       ID_ReadRs;
    logic       ID_ReadRt;
    logic       ID_ReadHiLo;
    logic       EXE_IsLoad;
    logic [4:0] EXE_Dst;
    RegsWrType  EXE_RegsWrType;
    logic       EXE_DivStart;
    logic       MEM_DReq;
    logic       MEM_DAck;
    logic       Exc_Flush;

    logic       PC_Stall;
    logic       IF_ID_Stall;
    logic       ID_EXE_Stall;
    logic       EXE_MEM_Stall;
    logic       MEM_WB_Stall;
    logic       IF_ID_Flush;
    logic       ID_EXE_Flush;
    logic       EXE_MEM_Flush;
    logic       Div_Busy;
    logic       Div_Done;

    modport master (
        output ID_rs, ID_rt, ID_ReadRs, ID_ReadRt, ID_ReadHiLo,
               EXE_IsLoad, EXE_Dst, EXE_RegsWrType, EXE_DivStart,
               MEM_DReq, MEM_DAck, Exc_Flush,
        input  PC_Stall, IF_ID_Stall, ID_EXE_Stall, EXE_MEM_Stall, MEM_WB_Stall,
               IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, Div_Busy, Div_Done
    );

    modport slave (
        input  ID_rs, ID_rt, ID_ReadRs, ID_ReadRt, ID_ReadHiLo,
               EXE_IsLoad, EXE_Dst, EXE_RegsWrType, EXE_DivStart,
               MEM_DReq, MEM_DAck, Exc_Flush,
        output PC_Stall, IF_ID_Stall, ID_EXE_Stall, EXE_MEM_Stall, MEM_WB_Stall,
               IF_ID_Flush, ID_EXE_Flush, EXE_MEM_Flush, Div_Busy, Div_Done
    );

endinterface

// File: rtl/hazard_ctrl_div_seq.sv
// rtl/hazard_ctrl_div_seq.sv - multi-cycle divider occupancy sequencer
//
// Purpose : IDLE -> BUSY (DIV_CYCLES-1 cycles) -> DONE -> IDLE.
// Ports   : clk, rst (sync, active-high); start = divide entered EXE;
//           abort = exception flush; hold = MEM stall keeps DONE alive;
//           busy/done = state decodes.
module div_seq
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic hold,
    output logic busy,
    output logic done
);

    DivState_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (abort) begin
            // The divide is younger than the faulting instruction: drop it.
            state_d = DIV_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        state_d = DIV_BUSY;
                        cnt_d   = CNT_W'(DIV_CYCLES - 1);
                    end
                end
                DIV_BUSY: begin
                    // Divider array runs independently of pipeline stalls.
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    // Keep the result visible until EXE can actually latch it.
                    if (!hold) begin
                        state_d = DIV_IDLE;
                    end
                end
                default: begin
                    state_d = DIV_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign busy = (state_q == DIV_BUSY);
    assign done = (state_q == DIV_DONE);

    // A second divide cannot reach EXE while one is in flight.
    a_no_start_when_active: assert property (
        @(posedge clk) disable iff (rst) !(start && (state_q != DIV_IDLE))
    );

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - 5-stage pipeline hazard detection and stall/flush priority
//
// Purpose : resolves load-use, divider occupancy, HI/LO-behind-divide and
//           data-cache wait hazards into per-stage stall/flush controls.
// Ports   : clk, rst (sync, active-high); hz = hazard_ctrl_if.slave carrying
//           ID/EXE/MEM status in and stall/flush/divider status out.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    logic       mem_wait;
    logic       load_use;
    logic       div_hold;
    logic       hilo_hazard;
    logic       div_busy;
    logic       div_done;
    logic       div_idle;
    logic       rs_hit;
    logic       rt_hit;
    logic       unused_wr;
    StallCtrl_t stall;
    FlushCtrl_t flush;

    div_seq #(
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_div_seq (
        .clk   (clk),
        .rst   (rst),
        .start (hz.EXE_DivStart),
        .abort (hz.Exc_Flush),
        .hold  (mem_wait),
        .busy  (div_busy),
        .done  (div_done)
    );

    assign div_idle = ~div_busy & ~div_done;
    assign mem_wait = hz.MEM_DReq & ~hz.MEM_DAck;

    assign rs_hit   = hz.ID_ReadRs & (hz.ID_rs == hz.EXE_Dst);
    assign rt_hit   = hz.ID_ReadRt & (hz.ID_rt == hz.EXE_Dst);
    // $0 is never a real dependency.
    assign load_use = hz.EXE_IsLoad & hz.EXE_RegsWrType.RFWr &
                      (hz.EXE_Dst != 5'd0) & (rs_hit | rt_hit);

    // The start cycle already counts: the divide must not leave EXE.
    assign div_hold    = div_busy | (div_idle & hz.EXE_DivStart);
    // DONE still needs a bubble: HI/LO is written at the EXE/MEM boundary.
    assign hilo_hazard = hz.ID_ReadHiLo & (div_hold | div_done);

    // Only RFWr matters for RF load-use.
    assign unused_wr = ^{hz.EXE_RegsWrType.HIWr, hz.EXE_RegsWrType.LOWr};

    always_comb begin
        stall = '0;
        flush = '0;
        if (hz.Exc_Flush) begin
            flush = '1;
        end else if (mem_wait) begin
            stall = '1;
        end else if (div_hold) begin
            stall.pc      = 1'b1;
            stall.if_id   = 1'b1;
            stall.id_exe  = 1'b1;
            flush.exe_mem = 1'b1;
        end else if (load_use || hilo_hazard) begin
            stall.pc      = 1'b1;
            stall.if_id   = 1'b1;
            flush.id_exe  = 1'b1;
        end
    end

    assign hz.PC_Stall      = stall.pc;
    assign hz.IF_ID_Stall   = stall.if_id;
    assign hz.ID_EXE_Stall  = stall.id_exe;
    assign hz.EXE_MEM_Stall = stall.exe_mem;
    assign hz.MEM_WB_Stall  = stall.mem_wb;
    assign hz.IF_ID_Flush   = flush.if_id;
    assign hz.ID_EXE_Flush  = flush.id_exe;
    assign hz.EXE_MEM_Flush = flush.exe_mem;
    assign hz.Div_Busy      = div_busy;
    assign hz.Div_Done      = div_done;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    // Output vector: {PC, IF_ID, ID_EXE, EXE_MEM, MEM_WB stalls,
    //                 IF_ID, ID_EXE, EXE_MEM flushes, Div_Busy, Div_Done}
    localparam logic [9:0] O_NONE = 10'b00000_000_00;
    localparam logic [9:0] O_LU   = 10'b11000_010_00;
    localparam logic [9:0] O_MW   = 10'b11111_000_00;
    localparam logic [9:0] O_EXC  = 10'b00000_111_00;
    localparam logic [9:0] O_DIVH = 10'b11100_001_00;
    localparam logic [9:0] B      = 10'b00000_000_10;
    localparam logic [9:0] D      = 10'b00000_000_01;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if hz();

    hazard_ctrl #(
        .DIV_CYCLES (32),
        .CNT_W      (6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    logic [9:0] exp_q[$];
    int         id_q[$];
    int         tests  = 0;
    int         failed = 0;
    int         vec    = 0;

    function automatic logic [9:0] outs();
        return {hz.PC_Stall, hz.IF_ID_Stall, hz.ID_EXE_Stall, hz.EXE_MEM_Stall,
                hz.MEM_WB_Stall, hz.IF_ID_Flush, hz.ID_EXE_Flush, hz.EXE_MEM_Flush,
                hz.Div_Busy, hz.Div_Done};
    endfunction

    // Monitor: compare the combinational outputs mid-cycle against the scoreboard.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [9:0] e;
            logic [9:0] a;
            int         id;
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            a  = outs();
            tests++;
            if (a !== e) begin
                failed++;
                $display("FAIL vec%0d: outputs=%b required=%b", id, a, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input logic [9:0] e);
        exp_q.push_back(e);
        id_q.push_back(vec);
        vec++;
        @(posedge clk);
        #1;
    endtask

    task automatic cycn(input int n, input logic [9:0] e);
        for (int i = 0; i < n; i++) cyc(e);
    endtask

    task automatic idle_inputs();
        hz.ID_rs          = 5'd0;
        hz.ID_rt          = 5'd0;
        hz.ID_ReadRs      = 1'b0;
        hz.ID_ReadRt      = 1'b0;
        hz.ID_ReadHiLo    = 1'b0;
        hz.EXE_IsLoad     = 1'b0;
        hz.EXE_Dst        = 5'd0;
        hz.EXE_RegsWrType = '0;
        hz.EXE_DivStart   = 1'b0;
        hz.MEM_DReq       = 1'b0;
        hz.MEM_DAck       = 1'b0;
        hz.Exc_Flush      = 1'b0;
    endtask

    // Clean divide: start cycle, 31 BUSY cycles, 1 DONE cycle, back to IDLE.
    task automatic div_full();
        hz.EXE_DivStart = 1'b1;
        cyc(O_DIVH);
        hz.EXE_DivStart = 1'b0;
        cycn(31, O_DIVH | B);
        cyc(D);
        cyc(O_NONE);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        cyc(O_NONE);                      // reset held, idle inputs
        rst = 1'b0;
        cyc(O_NONE);

        // Load-use on rs, then bubble cycle
        hz.EXE_IsLoad = 1'b1; hz.EXE_RegsWrType.RFWr = 1'b1; hz.EXE_Dst = 5'd5;
        hz.ID_rs = 5'd5; hz.ID_ReadRs = 1'b1;
        cyc(O_LU);
        hz.EXE_IsLoad = 1'b0; hz.EXE_Dst = 5'd0;
        cyc(O_NONE);
        // Load-use on rt only
        hz.EXE_IsLoad = 1'b1; hz.EXE_Dst = 5'd5; hz.ID_rs = 5'd3;
        hz.ID_rt = 5'd5; hz.ID_ReadRt = 1'b1;
        cyc(O_LU);
        hz.ID_ReadRt = 1'b0;              // rt matches but not consumed
        cyc(O_NONE);
        // Destination $0 never stalls
        hz.EXE_Dst = 5'd0; hz.ID_rs = 5'd0; hz.ID_rt = 5'd0;
        hz.ID_ReadRs = 1'b1; hz.ID_ReadRt = 1'b1;
        cyc(O_NONE);
        // Load without RF write, then RF-writing non-load
        hz.EXE_Dst = 5'd5; hz.ID_rs = 5'd5; hz.ID_ReadRt = 1'b0;
        hz.EXE_RegsWrType.RFWr = 1'b0;
        cyc(O_NONE);
        hz.EXE_RegsWrType.RFWr = 1'b1; hz.EXE_IsLoad = 1'b0;
        cyc(O_NONE);
        // Priority over load-use: mem_wait, ack resolves, exception wins
        hz.EXE_IsLoad = 1'b1;
        hz.MEM_DReq = 1'b1; hz.MEM_DAck = 1'b0;
        cyc(O_MW);
        hz.MEM_DAck = 1'b1;
        cyc(O_LU);
        hz.MEM_DAck = 1'b0; hz.Exc_Flush = 1'b1;
        cyc(O_EXC);
        idle_inputs();
        cyc(O_NONE);

        // Plain divide
        div_full();

        // Divide started under mem_wait, wait in BUSY, wait in DONE
        hz.EXE_DivStart = 1'b1; hz.MEM_DReq = 1'b1;
        cyc(O_MW);
        hz.EXE_DivStart = 1'b0;
        cycn(2, O_MW | B);
        hz.MEM_DReq = 1'b0;
        cycn(29, O_DIVH | B);
        hz.MEM_DReq = 1'b1;
        cycn(3, O_MW | D);
        hz.MEM_DAck = 1'b1;
        cyc(D);
        hz.MEM_DReq = 1'b0; hz.MEM_DAck = 1'b0;
        cyc(O_NONE);

        // mfhi waiting behind a divide
        hz.ID_ReadHiLo = 1'b1; hz.EXE_DivStart = 1'b1;
        cyc(O_DIVH);
        hz.EXE_DivStart = 1'b0;
        cycn(31, O_DIVH | B);
        cyc(O_LU | D);
        cyc(O_NONE);
        hz.ID_ReadHiLo = 1'b0;

        // Exception at BUSY cycle 10, coincident with mem_wait
        hz.EXE_DivStart = 1'b1;
        cyc(O_DIVH);
        hz.EXE_DivStart = 1'b0;
        cycn(9, O_DIVH | B);
        hz.Exc_Flush = 1'b1; hz.MEM_DReq = 1'b1;
        cyc(O_EXC | B);
        hz.Exc_Flush = 1'b0; hz.MEM_DReq = 1'b0;
        cyc(O_NONE);
        div_full();

        // Reset mid-BUSY, then a full-length restart
        hz.EXE_DivStart = 1'b1;
        cyc(O_DIVH);
        hz.EXE_DivStart = 1'b0;
        cycn(5, O_DIVH | B);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(O_NONE);
        div_full();

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            failed++;
            $display("FAIL drain: pending=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
